// File: rtl/mac_pkg.sv
// Shared constants and saturating-arithmetic helpers for the streaming MAC.
// Arithmetic runs on a fixed wide word so one function serves every ACC_WIDTH up to 62 bits.
package mac_pkg;

    localparam int unsigned WIDE_W = 64;

    typedef logic [WIDE_W-1:0] wide_t;

    typedef struct packed {
        logic  ovf;
        wide_t sum;
    } sat_res_t;

    localparam wide_t WIDE_ZERO = {WIDE_W{1'b0}};
    localparam wide_t WIDE_ONES = {WIDE_W{1'b1}};
    localparam wide_t WIDE_ONE  = {{(WIDE_W-1){1'b0}}, 1'b1};

    // Sign-extends a w-bit value held zero-extended in a wide word (signed mode only).
    function automatic wide_t ext_wide(input wide_t val, input int unsigned w, input logic signed_mode);
        wide_t res;
        if (signed_mode && ((val & (WIDE_ONE << (w - 32'd1))) != WIDE_ZERO)) begin
            res = val | (WIDE_ONES << w);
        end else begin
            res = val;
        end
        return res;
    endfunction

    function automatic wide_t acc_max(input int unsigned w, input logic signed_mode);
        wide_t res;
        if (signed_mode) begin
            res = (WIDE_ONE << (w - 32'd1)) - WIDE_ONE;
        end else begin
            res = (WIDE_ONE << w) - WIDE_ONE;
        end
        return res;
    endfunction

    function automatic wide_t acc_min(input int unsigned w, input logic signed_mode);
        wide_t res;
        if (signed_mode) begin
            res = ~((WIDE_ONE << (w - 32'd1)) - WIDE_ONE);
        end else begin
            res = WIDE_ZERO;
        end
        return res;
    endfunction

    // Adds two extended operands and clamps to the w-bit range; ovf flags a clamp.
    function automatic sat_res_t sat_add(input wide_t acc, input wide_t prod,
                                         input int unsigned w, input logic signed_mode);
        sat_res_t res;
        wide_t    sum;
        wide_t    hi;
        wide_t    lo;
        sum = acc + prod;
        hi  = acc_max(w, signed_mode);
        lo  = acc_min(w, signed_mode);
        if (signed_mode) begin
            if ($signed(sum) > $signed(hi)) begin
                res = '{ovf: 1'b1, sum: hi};
            end else if ($signed(sum) < $signed(lo)) begin
                res = '{ovf: 1'b1, sum: lo};
            end else begin
                res = '{ovf: 1'b0, sum: sum};
            end
        end else begin
            if (sum > hi) begin
                res = '{ovf: 1'b1, sum: hi};
            end else begin
                res = '{ovf: 1'b0, sum: sum};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_acc_stage.sv
// Second pipeline stage: saturating accumulator, term counter, sticky clamp flag
// and the one-entry result buffer with its valid/ready handshake.
module mac_acc_stage
    import mac_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned CNT_WIDTH  = 8,
    parameter bit          SIGNED     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  take_i,
    input  logic [PROD_WIDTH-1:0] prod_i,
    input  logic                  last_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [ACC_WIDTH-1:0]  out_acc_o,
    output logic [CNT_WIDTH-1:0]  out_count_o,
    output logic                  out_sat_o
);

    logic [ACC_WIDTH-1:0] acc_q, acc_d, oacc_q, oacc_d, sum_s;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_inc_s;
    logic                 sat_q, sat_d, osat_q, osat_d, ov_q, ov_d;
    sat_res_t             sat_res_s;

    assign sat_res_s = sat_add(ext_wide(WIDE_W'(acc_q), ACC_WIDTH, SIGNED),
                               ext_wide(WIDE_W'(prod_i), PROD_WIDTH, SIGNED),
                               ACC_WIDTH, SIGNED);
    assign sum_s     = ACC_WIDTH'(sat_res_s.sum);
    assign cnt_inc_s = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q
                                                    : cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Next state: accumulate a middle term, or hand a finished vector to the buffer.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        sat_d  = sat_q;
        oacc_d = oacc_q;
        ocnt_d = ocnt_q;
        osat_d = osat_q;
        ov_d   = ov_q;
        if (take_i && last_i) begin
            oacc_d = sum_s;
            ocnt_d = cnt_inc_s;
            osat_d = sat_q | sat_res_s.ovf;
            ov_d   = 1'b1;
            acc_d  = {ACC_WIDTH{1'b0}};
            cnt_d  = {CNT_WIDTH{1'b0}};
            sat_d  = 1'b0;
        end else if (take_i) begin
            acc_d = sum_s;
            cnt_d = cnt_inc_s;
            sat_d = sat_q | sat_res_s.ovf;
        end else begin
            acc_d = acc_q;
        end
        if (!(take_i && last_i) && ov_q && out_ready_i) begin
            ov_d = 1'b0;
        end else begin
            ov_d = ov_d;
        end
    end

    // State registers; clr flushes everything just like reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= {ACC_WIDTH{1'b0}};
            cnt_q  <= {CNT_WIDTH{1'b0}};
            sat_q  <= 1'b0;
            oacc_q <= {ACC_WIDTH{1'b0}};
            ocnt_q <= {CNT_WIDTH{1'b0}};
            osat_q <= 1'b0;
            ov_q   <= 1'b0;
        end else if (clr) begin
            acc_q  <= {ACC_WIDTH{1'b0}};
            cnt_q  <= {CNT_WIDTH{1'b0}};
            sat_q  <= 1'b0;
            oacc_q <= {ACC_WIDTH{1'b0}};
            ocnt_q <= {CNT_WIDTH{1'b0}};
            osat_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
            oacc_q <= oacc_d;
            ocnt_q <= ocnt_d;
            osat_q <= osat_d;
            ov_q   <= ov_d;
        end
    end

    assign out_valid_o = ov_q;
    assign out_acc_o   = oacc_q;
    assign out_count_o = ocnt_q;
    assign out_sat_o   = osat_q;

endmodule

// File: rtl/mac_stream.sv
// Streaming dot-product MAC: registered multiplier stage, then the accumulate/buffer stage.
// Input backpressure only arises when a finished vector waits behind an unread result.
module mac_stream
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned CNT_WIDTH  = 8,
    parameter bit          SIGNED     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_acc,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_sat
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    logic [PROD_WIDTH-1:0] a_ext_s, b_ext_s, prod_s, prod_q, prod_d;
    logic                  s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic                  stall_s, accept_s, take_s;

    // Extending both operands to product width makes the low half of one multiply right for either mode.
    assign a_ext_s = SIGNED ? {{DATA_WIDTH{in_a[DATA_WIDTH-1]}}, in_a} : {{DATA_WIDTH{1'b0}}, in_a};
    assign b_ext_s = SIGNED ? {{DATA_WIDTH{in_b[DATA_WIDTH-1]}}, in_b} : {{DATA_WIDTH{1'b0}}, in_b};
    assign prod_s  = a_ext_s * b_ext_s;

    assign stall_s  = out_valid && !out_ready && s1_valid_q && s1_last_q;
    assign in_ready = !stall_s;
    assign accept_s = in_valid && in_ready;
    assign take_s   = s1_valid_q && !stall_s;

    // S1 next state: hold while stalled, otherwise capture whatever is accepted.
    always_comb begin
        prod_d     = prod_q;
        s1_last_d  = s1_last_q;
        s1_valid_d = s1_valid_q;
        if (stall_s) begin
            s1_valid_d = s1_valid_q;
        end else if (accept_s) begin
            s1_valid_d = 1'b1;
            prod_d     = prod_s;
            s1_last_d  = in_last;
        end else begin
            s1_valid_d = 1'b0;
        end
    end

    // S1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q     <= {PROD_WIDTH{1'b0}};
            s1_last_q  <= 1'b0;
            s1_valid_q <= 1'b0;
        end else if (clr) begin
            prod_q     <= {PROD_WIDTH{1'b0}};
            s1_last_q  <= 1'b0;
            s1_valid_q <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            s1_last_q  <= s1_last_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    mac_acc_stage #(
        .PROD_WIDTH (PROD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .SIGNED     (SIGNED)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .take_i      (take_s),
        .prod_i      (prod_q),
        .last_i      (s1_last_q),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_acc_o   (out_acc),
        .out_count_o (out_count),
        .out_sat_o   (out_sat)
    );

endmodule
